// File: rtl/jackpot_pkg.sv
// Shared definitions for the jackpot round sequencer: state encoding,
// LED patterns and the random-start LFSR constants.
package jackpot_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WIN  = 2'd2,
    S_MISS = 2'd3
  } state_e;

  localparam logic [3:0]  LED_ALL    = 4'b1111;
  localparam logic [3:0]  LED_OFF    = 4'b0000;

  // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/jackpot_game_ctrl_if.sv
// Board-side bundle of the jackpot controller: pushbutton and switches in,
// LEDs and debug status out. master = board/driver side, slave = controller.
interface jackpot_game_ctrl_if #(
  parameter int unsigned LVL_W = 2,
  parameter int unsigned CNT_W = 8
);
  logic             START;
  logic [3:0]       SWITCHES;
  logic [3:0]       LEDS;
  logic [LVL_W-1:0] LEVEL;
  logic [CNT_W-1:0] WIN_COUNT;
  logic             GAME_ACTIVE;

  modport master (
    output START, SWITCHES,
    input  LEDS, LEVEL, WIN_COUNT, GAME_ACTIVE
  );

  modport slave (
    input  START, SWITCHES,
    output LEDS, LEVEL, WIN_COUNT, GAME_ACTIVE
  );
endinterface

// File: rtl/sw_sync_edge.sv
// W-bit two-flop synchroniser for asynchronous board inputs followed by a
// one-clock rising-edge pulse per bit.
module sw_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] meta_q, sync_q, prev_q;

  // Two synchroniser stages plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/jackpot_game_ctrl.sv
// Jackpot round sequencer: LED scan on a tick enable, synchronised switch
// edges, win/miss scoring with speed level and saturating win counter.
// Optional macro JACKPOT_RANDOM_START_EN: each entry into SCAN starts at a
// pseudo-random LED taken from a free-running 16-bit LFSR.
module jackpot_game_ctrl
  import jackpot_pkg::*;
#(
  parameter int unsigned DIV_BASE   = 31_250_000,
  parameter int unsigned LVL_W      = 2,
  parameter int unsigned WIN_TICKS  = 4,
  parameter int unsigned MISS_TICKS = 2,
  parameter int unsigned CNT_W      = 8
) (
  input logic                CLOCK,
  input logic                RESET_N,
  jackpot_game_ctrl_if.slave bus
);
  localparam int unsigned DIV_W    = (DIV_BASE > 2) ? $clog2(DIV_BASE) : 1;
  localparam int unsigned TICK_MAX = (WIN_TICKS > MISS_TICKS) ? WIN_TICKS : MISS_TICKS;
  localparam int unsigned TCNT_W   = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

  logic [3:0]       sw_rise;
  logic             start_rise;
  logic [1:0]       start_idx;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       leds_q, leds_d;
  logic             active_q, active_d;
  logic             restart;
  logic             tick;
  logic [DIV_W-1:0] div_last;
  logic [3:0]       idx_mask;

  sw_sync_edge #(.W(4)) u_sw_sync (
    .clk    (CLOCK),
    .rst_n  (RESET_N),
    .d_i    (bus.SWITCHES),
    .rise_o (sw_rise)
  );

  sw_sync_edge #(.W(1)) u_start_sync (
    .clk    (CLOCK),
    .rst_n  (RESET_N),
    .d_i    (bus.START),
    .rise_o (start_rise)
  );

`ifdef JACKPOT_RANDOM_START_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Free-running Galois LFSR step
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // LFSR state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign start_idx = lfsr_q[1:0];
`else
  assign start_idx = 2'd0;
`endif

  // Tick on the terminal count of the level-scaled divider
  always_comb begin
    div_last = DIV_W'((DIV_BASE >> level_q) - 1);
    tick     = (div_q == div_last);
    idx_mask = 4'b0001 << idx_q;
  end

  // Next-state, scoring and registered-output computation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    level_d = level_q;
    count_d = count_q;
    tcnt_d  = tcnt_q;
    restart = 1'b0;

    if (start_rise) begin
      // START always (re)starts a fresh game, whatever the state
      restart = 1'b1;
      state_d = S_SCAN;
      idx_d   = start_idx;
      level_d = '0;
      count_d = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        S_SCAN: begin
          // Judged against the current idx, so a rise on the tick edge
          // scores against the LED that was lit before the advance
          if ((sw_rise & ~idx_mask) != 4'b0000) begin
            state_d = S_MISS;
            level_d = '0;
            tcnt_d  = '0;
          end else if ((sw_rise & idx_mask) != 4'b0000) begin
            state_d = S_WIN;
            count_d = (&count_q) ? count_q : count_q + 1'b1;
            level_d = (&level_q) ? level_q : level_q + 1'b1;
            tcnt_d  = '0;
          end else if (tick) begin
            idx_d = idx_q + 2'd1;
          end
        end
        S_WIN: begin
          if (tick) begin
            if (tcnt_q == TCNT_W'(WIN_TICKS - 1)) begin
              state_d = S_SCAN;
              idx_d   = start_idx;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
        S_MISS: begin
          if (tick) begin
            if (tcnt_q == TCNT_W'(MISS_TICKS - 1)) begin
              state_d = S_SCAN;
              idx_d   = start_idx;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // Every phase starts a full tick period from zero
    if (restart || (state_d != state_q) || (level_d != level_q) || tick) div_d = '0;
    else                                                                div_d = div_q + 1'b1;

    case (state_d)
      S_SCAN:  leds_d = 4'b0001 << idx_d;
      S_WIN:   leds_d = LED_ALL;
      default: leds_d = LED_OFF;
    endcase
    active_d = (state_d != S_IDLE);
  end

  // Single state/output register bank
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      level_q  <= '0;
      count_q  <= '0;
      tcnt_q   <= '0;
      div_q    <= '0;
      leds_q   <= LED_OFF;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      level_q  <= level_d;
      count_q  <= count_d;
      tcnt_q   <= tcnt_d;
      div_q    <= div_d;
      leds_q   <= leds_d;
      active_q <= active_d;
    end
  end

  assign bus.LEDS        = leds_q;
  assign bus.LEVEL       = level_q;
  assign bus.WIN_COUNT   = count_q;
  assign bus.GAME_ACTIVE = active_q;
endmodule
